// File: rtl/des_pkg.sv
// Shared DES datapath definitions: block/key widths and the block
// sequencer state encoding.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_KEY_W   = 64;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_RUN    = 3'd2,
    SEQ_ACK    = 3'd3,
    SEQ_CLEAR  = 3'd4,
    SEQ_EMIT   = 3'd5,
    SEQ_FINISH = 3'd6
  } des_seq_state_t;

endpackage

// File: rtl/des_block_sequencer_if.sv
// Bundle of run-control, ciphertext source, plaintext sink and DES core
// signals seen by the block sequencer (master) and its environment (slave).
interface des_block_sequencer_if #(
  parameter int CNT_W = 16
);
  import des_pkg::*;

  logic                   start;
  logic [DES_KEY_W-1:0]   key;
  logic [DES_BLOCK_W-1:0] iv;
  logic                   cbc;
  logic [CNT_W-1:0]       num_blocks;
  logic                   in_valid;
  logic [DES_BLOCK_W-1:0] in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [DES_BLOCK_W-1:0] out_data;
  logic                   out_ready;
  logic [DES_BLOCK_W-1:0] core_message;
  logic [DES_KEY_W-1:0]   core_key;
  logic                   core_enable;
  logic                   core_ack;
  logic [DES_BLOCK_W-1:0] core_result;
  logic                   core_done;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, key, iv, cbc, num_blocks, in_valid, in_data, out_ready,
           core_result, core_done,
    output in_ready, out_valid, out_data, core_message, core_key,
           core_enable, core_ack, busy, done
  );

  modport slave (
    output start, key, iv, cbc, num_blocks, in_valid, in_data, out_ready,
           core_result, core_done,
    input  in_ready, out_valid, out_data, core_message, core_key,
           core_enable, core_ack, busy, done
  );

endinterface

// File: rtl/des_block_sequencer.sv
// Streams a run of ciphertext blocks through an external DES decrypt core,
// one enable/done/ack handshake per block, with optional CBC chaining.
//
// state  | meaning
// IDLE   | waiting for start; config latched on start
// FETCH  | in_ready high, waiting for a ciphertext block
// RUN    | core_enable high, waiting for core_done
// ACK    | one-cycle core_ack
// CLEAR  | waiting for core_done to drop; forms plaintext
// EMIT   | out_valid high until the sink accepts
// FINISH | one-cycle done pulse
module des_block_sequencer
  import des_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  des_block_sequencer_if.master  bus
);

  localparam logic [2:0] ST_IDLE   = SEQ_IDLE;
  localparam logic [2:0] ST_FETCH  = SEQ_FETCH;
  localparam logic [2:0] ST_RUN    = SEQ_RUN;
  localparam logic [2:0] ST_ACK    = SEQ_ACK;
  localparam logic [2:0] ST_CLEAR  = SEQ_CLEAR;
  localparam logic [2:0] ST_EMIT   = SEQ_EMIT;
  localparam logic [2:0] ST_FINISH = SEQ_FINISH;

  logic [2:0]             r_state;
  logic [DES_KEY_W-1:0]   r_key;
  logic [DES_BLOCK_W-1:0] r_chain;
  logic                   r_cbc;
  logic [CNT_W-1:0]       r_remaining;
  logic [DES_BLOCK_W-1:0] r_block;
  logic [DES_BLOCK_W-1:0] r_result;
  logic [DES_BLOCK_W-1:0] r_out_data;

  // All handshake outputs are pure state decodes, so the exclusivity
  // between in_ready/out_valid and core_ack/core_enable holds by design.
  assign bus.in_ready     = (r_state == ST_FETCH);
  assign bus.core_enable  = (r_state == ST_RUN);
  assign bus.core_ack     = (r_state == ST_ACK);
  assign bus.out_valid    = (r_state == ST_EMIT);
  assign bus.done         = (r_state == ST_FINISH);
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.out_data     = r_out_data;
  assign bus.core_message = r_block;
  assign bus.core_key     = r_key;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_chain     <= '0;
      r_cbc       <= 1'b0;
      r_remaining <= '0;
      r_block     <= '0;
      r_result    <= '0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_key       <= bus.key;
            r_chain     <= bus.iv;
            r_cbc       <= bus.cbc;
            r_remaining <= bus.num_blocks;
            r_state     <= (bus.num_blocks == '0) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.in_valid) begin
            r_block <= bus.in_data;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.core_done) begin
            r_result <= bus.core_result;
            r_state  <= ST_ACK;
          end
        end
        ST_ACK: r_state <= ST_CLEAR;
        ST_CLEAR: begin
          // The core must release done before the next block may enable it.
          if (!bus.core_done) begin
            r_out_data  <= r_cbc ? (r_result ^ r_chain) : r_result;
            if (r_cbc) r_chain <= r_block;
            r_remaining <= r_remaining - CNT_W'(1);
            r_state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bus.out_ready)
            r_state <= (r_remaining != '0) ? ST_FETCH : ST_FINISH;
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_block_sequencer.sv
// Self-checking bench for des_block_sequencer: stub DES core, scoreboard of
// expected plaintext, handshake timing and exclusivity checks.
module tb_des_block_sequencer;
  import des_pkg::*;

  localparam logic [63:0] K0 = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] C0 = 64'h85E8_1354_0F0A_B405;
  localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic reset;
  des_block_sequencer_if #(.CNT_W(16)) sif ();

  des_block_sequencer #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          en_cnt  = 0;
  int          core_lat = 3;
  int          c_cnt;
  logic [63:0] sb_q[$];
  logic [63:0] m_key, m_chain;
  logic        m_cbc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stub decrypt: the known DES vector plus an arbitrary keyed mix otherwise.
  function automatic logic [63:0] core_fn(input logic [63:0] k, input logic [63:0] m);
    if (k == K0 && m == C0) return P0;
    return m ^ {k[31:0], k[63:32]} ^ 64'h5A5A_0F0F_3C3C_9696;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sif.core_done   <= 1'b0;
      sif.core_result <= '0;
      c_cnt           <= 0;
    end else if (sif.core_ack) begin
      sif.core_done <= 1'b0;
    end else if (sif.core_enable && !sif.core_done) begin
      if (c_cnt + 1 >= core_lat) begin
        sif.core_done   <= 1'b1;
        sif.core_result <= core_fn(sif.core_key, sif.core_message);
        c_cnt           <= 0;
      end else begin
        c_cnt <= c_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (sif.core_enable) en_cnt++;
    if (!reset) begin
      chk("excl_rdy_val", 64'(sif.in_ready & sif.out_valid), 0);
      chk("excl_ack_en", 64'(sif.core_ack & sif.core_enable), 0);
    end
  end

  task automatic do_start(input logic [63:0] k, input logic [63:0] iv,
                          input logic c, input logic [15:0] n);
    m_key = k; m_chain = iv; m_cbc = c;
    sif.start = 1'b1; sif.key = k; sif.iv = iv; sif.cbc = c; sif.num_blocks = n;
    @(negedge clk);
    sif.start = 1'b0;
    chk("start_busy", sif.busy, 1);
    chk("start_in_ready", sif.in_ready, (n != 0));
    chk("start_done", sif.done, (n == 0));
    if (n == 0) begin
      @(negedge clk);
      chk("zero_busy_clr", sif.busy, 0);
    end
  endtask

  // mode 0: normal, 1: pulse start mid-RUN, 2: reset mid-RUN
  task automatic feed(input logic [63:0] blk, input int mode);
    int k = 0;
    logic [63:0] e;
    while (!sif.in_ready && k < 500) begin @(negedge clk); k++; end
    chk("in_ready_wait", sif.in_ready, 1);
    e = core_fn(m_key, blk) ^ (m_cbc ? m_chain : 64'h0);
    if (m_cbc) m_chain = blk;
    sb_q.push_back(e);
    sif.in_valid = 1'b1; sif.in_data = blk;
    @(negedge clk);
    sif.in_valid = 1'b0;
    chk("en_after_fetch", sif.core_enable, 1);
    chk("core_msg", sif.core_message, blk);
    chk("core_key", sif.core_key, m_key);
    if (mode == 2) begin
      reset = 1'b1;
      #1;
      chk("rst_ctrl", {sif.busy, sif.in_ready, sif.out_valid, sif.core_enable,
                       sif.core_ack, sif.done}, 0);
      chk("rst_out_data", sif.out_data, 0);
      chk("rst_core_key", sif.core_key, 0);
      chk("rst_core_msg", sif.core_message, 0);
      sb_q.delete();
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    if (mode == 1) begin
      sif.start = 1'b1; sif.key = ~m_key; sif.num_blocks = 16'd0;
      @(negedge clk);
      sif.start = 1'b0;
      chk("inj_key", sif.core_key, m_key);
      chk("inj_en", sif.core_enable, 1);
    end
    k = 0;
    while (!sif.core_done && k < 500) begin @(negedge clk); k++; end
    chk("core_done_wait", sif.core_done, 1);
    @(negedge clk);
    chk("ack_on", sif.core_ack, 1);
    chk("en_off_ack", sif.core_enable, 0);
  endtask

  task automatic take(input int stall, input bit last);
    int k = 0;
    logic [63:0] d0;
    bit stable = 1'b1;
    while (!sif.out_valid && k < 500) begin @(negedge clk); k++; end
    chk("out_valid_wait", sif.out_valid, 1);
    d0 = sif.out_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!sif.out_valid || sif.out_data !== d0 || sif.in_ready || sif.core_enable)
        stable = 1'b0;
    end
    if (stall > 0) chk("bp_stable", 64'(stable), 1);
    sif.out_ready = 1'b1;
    if (sb_q.size() == 0) chk("sb_empty", 1, 0);
    else chk("out_data", sif.out_data, sb_q.pop_front());
    @(negedge clk);
    sif.out_ready = 1'b0;
    if (last) begin
      chk("done_pulse", sif.done, 1);
      @(negedge clk);
      chk("busy_clr", sif.busy, 0);
      chk("done_clr", sif.done, 0);
    end else begin
      chk("next_fetch", sif.in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [63:0] r0;
    reset = 1'b1;
    sif.start = 0; sif.key = 0; sif.iv = 0; sif.cbc = 0; sif.num_blocks = 0;
    sif.in_valid = 0; sif.in_data = 0; sif.out_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {sif.busy, sif.in_ready, sif.out_valid, sif.core_enable,
                       sif.core_ack, sif.done}, 0);
    chk("reset_out_data", sif.out_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // ECB single block, known vector
    do_start(K0, 64'h0, 1'b0, 16'd1);
    feed(C0, 0);
    take(0, 1);

    // CBC two blocks, iv 0
    do_start(K0, 64'h0, 1'b1, 16'd2);
    feed(C0, 0);
    take(0, 0);
    feed(C0, 0);
    chk("cbc_vec2", sb_q[0], 64'h84CB_5633_86A1_79EA);
    take(0, 1);

    // CBC three random blocks with sink backpressure on the middle one
    core_lat = 5;
    do_start({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 16'd3);
    for (int i = 0; i < 3; i++) begin
      feed({$urandom, $urandom}, 0);
      take((i == 1) ? 20 : 0, (i == 2));
    end

    // Zero-length run
    e0 = en_cnt;
    do_start(K0, 64'h0, 1'b0, 16'd0);
    repeat (5) @(negedge clk);
    chk("zero_no_enable", 64'(en_cnt - e0), 0);

    // Reset in RUN, then a clean ECB run
    do_start({$urandom, $urandom}, 64'h0, 1'b0, 16'd1);
    feed({$urandom, $urandom}, 2);
    @(negedge clk);
    chk("post_rst_idle", sif.busy, 0);
    do_start(K0, 64'h0, 1'b0, 16'd1);
    feed(C0, 0);
    take(0, 1);

    // Start pulsed during RUN must be ignored
    core_lat = 8;
    r0 = {$urandom, $urandom};
    do_start(r0, {$urandom, $urandom}, 1'b1, 16'd1);
    feed({$urandom, $urandom}, 1);
    take(0, 1);

    chk("sb_drained", 64'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des_block_sequencer.md
# des_block_sequencer

Controller that streams a run of 64-bit blocks through one external DES `decrypt` core (`message`/`DESkey`/`enable`/`ack`/`done`/`decrypted`). It takes ciphertext blocks from an upstream valid/ready source and sequences the core's enable/done/ack handshake once per block. It applies optional CBC chaining and delivers plaintext blocks to a downstream valid/ready sink. It sits between the image block buffer and the DES core in the ImageAES datapath.

## Interface
- `CNT_W`, 16, width of block-count input
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; latches `key`, `iv`, `cbc`, `num_blocks`; ignored while `busy`
- `key`  in  64  DES key (parity bits included)
- `iv`  in  64  CBC initial vector
- `cbc`  in  1  1 = CBC decrypt, 0 = ECB
- `num_blocks`  in  CNT_W  blocks in this run
- `in_valid` / `in_data`  in  1 / 64  ciphertext source
- `in_ready`  out  1  source handshake
- `out_valid` / `out_data`  out  1 / 64  plaintext sink
- `out_ready`  in  1  sink handshake
- `core_message`, `core_key`  out  64 each  to core `message`, `DESkey`
- `core_enable`, `core_ack`  out  1 each  to core `enable`, `ack`
- `core_result`  in  64  from core `decrypted`
- `core_done`  in  1  from core `done`
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, FETCH, RUN, ACK, CLEAR, EMIT, FINISH.
- IDLE: on `start`, latch the config, set chain ← `iv`, set remaining ← `num_blocks`, then go to FETCH. If `num_blocks`=0, go directly to FINISH.
- FETCH: `in_ready`=1. On `in_valid`, capture `in_data` into a block register and go to RUN.
- RUN: `core_enable`=1 with `core_message`=block register and `core_key`=latched key. Hold until `core_done`=1. Then capture `core_result` and go to ACK.
- ACK: `core_enable`=0 and `core_ack`=1 for exactly one cycle. Go to CLEAR.
- CLEAR: wait for `core_done`=0. Then compute `out_data` = result XOR chain (CBC) or result (ECB). In CBC, chain ← block register. Decrement remaining and go to EMIT.
- EMIT: `out_valid`=1 with `out_data` held stable. On `out_ready`, go to FETCH if remaining≠0, else to FINISH.
- FINISH: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `start` outside IDLE is ignored, with no effect on the latched config.
- Reset (any time, including mid-block) forces IDLE. All outputs go to 0, including `core_enable`, `core_ack` and `out_data`. The internal registers also clear to 0.
- The remaining-block counter is CNT_W bits and decrements only in CLEAR, so it never wraps.

## Timing
- `start` at cycle T gives `busy`=1 and `in_ready`=1 at T+1. With `num_blocks`=0, `done`=`busy`=1 at T+1 and `busy`=0 at T+2.
- Input handshake at F gives `core_enable`=1 from F+1.
- `core_done` seen at D gives `core_ack`=1 and `core_enable`=0 at D+1.
- `core_done` low at C gives `out_valid`=1 at C+1.
- Output handshake at E: `in_ready`=1 at E+1 (more blocks) or `done`=1 at E+1 (last block). `busy`=0 at E+2.
- Overhead is 4 cycles per block plus core latency plus sink stall. Blocks are not overlapped.
- `in_ready` and `out_valid` are never high in the same cycle. `core_ack` and `core_enable` are never high in the same cycle.

## Structure
- Shared package `des_pkg`: `DES_BLOCK_W`=64, `DES_KEY_W`=64, and the state enum `des_seq_state_t`.
- Single flat module. No sub-module is natural. The `decrypt` core is instantiated by the parent, not inside this block.

## Test plan
- ECB, 1 block: key 133457799BBCDFF1, in 85E813540F0AB405 → out 0123456789ABCDEF, then `done` pulse one cycle after the output handshake.
- CBC, 2 blocks: iv 0, in 85E813540F0AB405 twice → out 0123456789ABCDEF, then 84CB563386A179EA.
- Backpressure: hold `out_ready`=0 for 20 cycles in EMIT → `out_valid` and `out_data` stay stable, `in_ready`=0, `core_enable`=0.
- `num_blocks`=0 → `done`=1 at T+1 and no `core_enable` ever asserted.
- Reset asserted while `core_enable`=1 → all outputs 0 immediately. A following 1-block ECB run completes correctly.
- `start` pulsed during RUN with a different key → ignored; `core_key` is unchanged and the current run completes with the original result.
